audio_event_arbiter: RTL and testbench

Schedules game sound events onto the single audio processing unit. The arbiter takes edge-detected eat, hit and die requests from the game logic and queues them by priority. It holds exactly one APU trigger line high for a per-sound duration counted in frames, then inserts a silent gap between sounds. It sits between the collision/trigger logic and the APU's saw/square/noise trigger inputs.

---
 rtl/audio_event_arbiter.sv | 160 ++++++++++++++++
 tb/tb_audio_event_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_event_arbiter.sv
// Priority scheduler of eat/hit/die sound events onto one APU: request edge -> pending (1 edge) -> trigger (1 edge).
// No backpressure: repeated requests coalesce into one pending bit; higher priority preempts the active sound.
module audio_event_arbiter #(
    parameter logic [7:0] EAT_FRAMES = 8'd8,
    parameter logic [7:0] HIT_FRAMES = 8'd12,
    parameter logic [7:0] DIE_FRAMES = 8'd30,
    parameter logic [7:0] GAP_FRAMES = 8'd2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_end,
    input  logic       req_eat,
    input  logic       req_hit,
    input  logic       req_die,
    input  logic       mute,
    output logic       saw_trigger,
    output logic       square_trigger,
    output logic       noise_trigger,
    output logic [1:0] active_sound,
    output logic [2:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // A zero duration would never end cleanly, so it plays as one frame.
    localparam logic [7:0] EAT_LEN = (EAT_FRAMES == 8'd0) ? 8'd1 : EAT_FRAMES;
    localparam logic [7:0] HIT_LEN = (HIT_FRAMES == 8'd0) ? 8'd1 : HIT_FRAMES;
    localparam logic [7:0] DIE_LEN = (DIE_FRAMES == 8'd0) ? 8'd1 : DIE_FRAMES;

    state_t     state_q, state_d;
    logic [2:0] req_q;
    logic [2:0] pending_q, pending_d;
    logic [7:0] dur_q, dur_d;
    logic [7:0] gap_q, gap_d;
    logic [1:0] sound_q, sound_d;
    logic [2:0] trig_q, trig_d;

    logic [2:0] req_vec;
    logic [2:0] edge_vec;
    logic [1:0] top_code;
    logic [2:0] top_mask;
    logic [7:0] top_len;
    logic       grant;

    assign req_vec  = {req_die, req_hit, req_eat};
    assign edge_vec = req_vec & ~req_q;

    // Sound codes double as priority ranks: die=3 > hit=2 > eat=1.
    always_comb begin
        top_code = 2'd0;
        top_mask = 3'b000;
        top_len  = 8'd1;
        if (pending_q[2]) begin
            top_code = 2'd3;
            top_mask = 3'b100;
            top_len  = DIE_LEN;
        end else if (pending_q[1]) begin
            top_code = 2'd2;
            top_mask = 3'b010;
            top_len  = HIT_LEN;
        end else if (pending_q[0]) begin
            top_code = 2'd1;
            top_mask = 3'b001;
            top_len  = EAT_LEN;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | edge_vec;
        dur_d     = dur_q;
        gap_d     = gap_q;
        sound_d   = sound_q;
        trig_d    = trig_q;
        grant     = 1'b0;

        if (mute) begin
            state_d   = S_IDLE;
            pending_d = 3'b000;
            dur_d     = 8'd0;
            gap_d     = 8'd0;
            sound_d   = 2'd0;
            trig_d    = 3'b000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (top_code != 2'd0) grant = 1'b1;
                end
                S_PLAY: begin
                    if (top_code > sound_q) begin
                        grant = 1'b1;
                    end else if (frame_end) begin
                        if (dur_q <= 8'd1) begin
                            trig_d  = 3'b000;
                            sound_d = 2'd0;
                            if (GAP_FRAMES == 8'd0) begin
                                state_d = S_IDLE;
                                gap_d   = 8'd0;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = GAP_FRAMES;
                            end
                        end else begin
                            dur_d = dur_q - 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (frame_end) begin
                        if (gap_q <= 8'd1) state_d = S_IDLE;
                        else               gap_d   = gap_q - 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A new edge in the grant cycle is a fresh request and stays pending.
            if (grant) begin
                state_d   = S_PLAY;
                pending_d = (pending_q & ~top_mask) | edge_vec;
                dur_d     = top_len;
                sound_d   = top_code;
                trig_d    = top_mask;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            req_q     <= 3'b000;
            pending_q <= 3'b000;
            dur_q     <= 8'd0;
            gap_q     <= 8'd0;
            sound_q   <= 2'd0;
            trig_q    <= 3'b000;
        end else begin
            state_q   <= state_d;
            req_q     <= req_vec;
            pending_q <= pending_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            sound_q   <= sound_d;
            trig_q    <= trig_d;
        end
    end

    assign saw_trigger    = trig_q[0];
    assign square_trigger = trig_q[1];
    assign noise_trigger  = trig_q[2];
    assign active_sound   = sound_q;
    assign pending        = pending_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_event_arbiter.sv
// Directed bench for audio_event_arbiter: hand-computed output vectors after chosen clock edges.
module tb_audio_event_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_end;
    logic       req_eat;
    logic       req_hit;
    logic       req_die;
    logic       mute;
    logic       saw_trigger;
    logic       square_trigger;
    logic       noise_trigger;
    logic [1:0] active_sound;
    logic [2:0] pending;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    audio_event_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_end      (frame_end),
        .req_eat        (req_eat),
        .req_hit        (req_hit),
        .req_die        (req_die),
        .mute           (mute),
        .saw_trigger    (saw_trigger),
        .square_trigger (square_trigger),
        .noise_trigger  (noise_trigger),
        .active_sound   (active_sound),
        .pending        (pending),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Each frame: 9 quiet cycles, then one cycle with frame_end high.
    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            tick(9);
            frame_end = 1'b1;
            tick(1);
            frame_end = 1'b0;
        end
    endtask

    // Vector layout: {noise, square, saw, active_sound, pending, busy}
    task automatic chk(input string tag, input logic [2:0] trg, input logic [1:0] act,
                       input logic [2:0] pnd, input logic bsy);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {noise_trigger, square_trigger, saw_trigger, active_sound, pending, busy};
        exp = {trg, act, pnd, bsy};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        frame_end = 1'b0;
        req_eat   = 1'b0;
        req_hit   = 1'b0;
        req_die   = 1'b0;
        mute      = 1'b0;
        tick(2);
        chk("reset", 3'b000, 2'd0, 3'b000, 1'b0);
        rst_n = 1'b1;
        tick(1);
        chk("post_reset", 3'b000, 2'd0, 3'b000, 1'b0);

        // Single eat
        req_eat = 1'b1;
        tick(1);
        chk("eat_pend", 3'b000, 2'd0, 3'b001, 1'b0);
        req_eat = 1'b0;
        tick(1);
        chk("eat_grant", 3'b001, 2'd1, 3'b000, 1'b1);
        frames(7);
        chk("eat_f7", 3'b001, 2'd1, 3'b000, 1'b1);
        frames(1);
        chk("eat_f8_gap", 3'b000, 2'd0, 3'b000, 1'b1);
        frames(1);
        chk("eat_gap1", 3'b000, 2'd0, 3'b000, 1'b1);
        frames(1);
        chk("eat_idle", 3'b000, 2'd0, 3'b000, 1'b0);

        // Simultaneous requests
        req_eat = 1'b1;
        req_hit = 1'b1;
        req_die = 1'b1;
        tick(1);
        chk("all_pend", 3'b000, 2'd0, 3'b111, 1'b0);
        req_eat = 1'b0;
        req_hit = 1'b0;
        req_die = 1'b0;
        tick(1);
        chk("all_die", 3'b100, 2'd3, 3'b011, 1'b1);
        frames(29);
        chk("all_die_f29", 3'b100, 2'd3, 3'b011, 1'b1);
        frames(1);
        chk("all_die_end", 3'b000, 2'd0, 3'b011, 1'b1);
        frames(2);
        chk("all_gap1_end", 3'b000, 2'd0, 3'b011, 1'b0);
        tick(1);
        chk("all_hit", 3'b010, 2'd2, 3'b001, 1'b1);
        frames(11);
        chk("all_hit_f11", 3'b010, 2'd2, 3'b001, 1'b1);
        frames(1);
        chk("all_hit_end", 3'b000, 2'd0, 3'b001, 1'b1);
        frames(2);
        tick(1);
        chk("all_eat", 3'b001, 2'd1, 3'b000, 1'b1);
        frames(8);
        chk("all_eat_end", 3'b000, 2'd0, 3'b000, 1'b1);
        frames(2);
        chk("all_idle", 3'b000, 2'd0, 3'b000, 1'b0);

        // Preemption of a hit by a die during frame 3
        req_hit = 1'b1;
        tick(1);
        req_hit = 1'b0;
        tick(1);
        chk("pre_hit", 3'b010, 2'd2, 3'b000, 1'b1);
        frames(2);
        req_die = 1'b1;
        tick(1);
        chk("pre_die_pend", 3'b010, 2'd2, 3'b100, 1'b1);
        req_die = 1'b0;
        tick(1);
        chk("pre_swap", 3'b100, 2'd3, 3'b000, 1'b1);
        frames(30);
        chk("pre_die_end", 3'b000, 2'd0, 3'b000, 1'b1);
        frames(2);
        tick(3);
        chk("pre_no_replay", 3'b000, 2'd0, 3'b000, 1'b0);

        // Three eat edges during a die coalesce
        req_die = 1'b1;
        tick(1);
        req_die = 1'b0;
        tick(1);
        chk("coal_die", 3'b100, 2'd3, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            req_eat = 1'b1;
            tick(1);
            req_eat = 1'b0;
            tick(1);
        end
        chk("coal_pend", 3'b100, 2'd3, 3'b001, 1'b1);
        frames(30);
        frames(2);
        chk("coal_idle", 3'b000, 2'd0, 3'b001, 1'b0);
        tick(1);
        chk("coal_eat", 3'b001, 2'd1, 3'b000, 1'b1);
        frames(8);
        frames(2);
        tick(2);
        chk("coal_once", 3'b000, 2'd0, 3'b000, 1'b0);

        // Mute mid-sound with a hit pending
        req_die = 1'b1;
        tick(1);
        req_die = 1'b0;
        tick(1);
        frames(3);
        req_hit = 1'b1;
        tick(1);
        chk("mute_setup", 3'b100, 2'd3, 3'b010, 1'b1);
        req_hit = 1'b0;
        mute = 1'b1;
        tick(1);
        chk("mute_flush", 3'b000, 2'd0, 3'b000, 1'b0);
        req_eat = 1'b1;
        tick(2);
        chk("mute_ignore", 3'b000, 2'd0, 3'b000, 1'b0);
        mute = 1'b0;
        tick(3);
        chk("unmute_level", 3'b000, 2'd0, 3'b000, 1'b0);
        req_eat = 1'b0;
        tick(1);

        // Async reset mid-hit, hit held across release
        req_hit = 1'b1;
        tick(1);
        req_hit = 1'b0;
        tick(1);
        frames(2);
        chk("rst_hit_play", 3'b010, 2'd2, 3'b000, 1'b1);
        #2;
        rst_n = 1'b0;
        req_hit = 1'b1;
        #1;
        chk("rst_async", 3'b000, 2'd0, 3'b000, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("rst_held_edge", 3'b000, 2'd0, 3'b010, 1'b0);
        frame_end = 1'b1;
        tick(1);
        frame_end = 1'b0;
        chk("rst_hit_grant", 3'b010, 2'd2, 3'b000, 1'b1);
        frames(11);
        chk("rst_hit_f11", 3'b010, 2'd2, 3'b000, 1'b1);
        frames(1);
        chk("rst_hit_end", 3'b000, 2'd0, 3'b000, 1'b1);
        frames(2);
        tick(2);
        chk("rst_hit_once", 3'b000, 2'd0, 3'b000, 1'b0);
        req_hit = 1'b0;
        tick(2);
        chk("final_idle", 3'b000, 2'd0, 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
